// File: rtl/ram_sdp_parity.sv
// ram_sdp_parity: simple-dual-port RAM (one write port, one read port, one clock)
// with per-byte write enables, per-byte stored parity checked on read, selectable
// read-during-write behaviour, a post-reset zeroing sweep and 1- or 2-cycle read
// latency qualified by dout_valid.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   blk_select          gates both ports
//   wr_en/wr_addr/wr_be/din/err_inject   write port (err_inject stores inverted parity)
//   rd_en/rd_addr       read request
//   dout/dout_valid     read data and its one-cycle qualifier
//   parity_err          parity mismatch on the current dout (only with dout_valid)
//   parity_err_sticky   latched parity_err, cleared by reset only
//   init_busy           zeroing sweep in progress; requests are dropped
module ram_sdp_parity #(
  parameter int    MEM_WIDTH     = 16,
  parameter int    MEM_DEPTH     = 1024,
  parameter int    ADDR_SIZE     = 10,
  parameter int    BYTE_WIDTH    = 8,
  parameter string DOUT_PIPELINE = "TRUE",
  parameter string RDW_MODE      = "READ_FIRST",
  parameter int    PARITY_ENABLE = 1,
  parameter int    INIT_CLEAR    = 1,
  localparam int   NB            = MEM_WIDTH / BYTE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 blk_select,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [NB-1:0]        wr_be,
  input  logic [MEM_WIDTH-1:0] din,
  input  logic                 err_inject,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 parity_err,
  output logic                 parity_err_sticky,
  output logic                 init_busy
);

  localparam int IW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam bit PIPE2  = (DOUT_PIPELINE == "TRUE");
  localparam bit WFIRST = (RDW_MODE == "WRITE_FIRST");

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  cnt_q, cnt_d;

  // Storage array: not reset, cleared by the sweep instead.
  logic [MEM_WIDTH-1:0] mem_data [MEM_DEPTH];
  logic [NB-1:0]        mem_par  [MEM_DEPTH];

  logic                 run, wr_ok, rd_ok, rd_in_range;
  logic [IW-1:0]        wa, ra;
  logic [NB-1:0]        wr_par;
  logic [MEM_WIDTH-1:0] rd_word;
  logic [NB-1:0]        rd_par;
  logic                 rd_mm;

  // Read pipeline: index 0 is the first register stage, index 1 the optional second.
  logic [1:0]           vld_pipe_q, vld_pipe_d;
  logic [1:0]           err_pipe_q, err_pipe_d;
  logic [MEM_WIDTH-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
  logic                 sticky_q, sticky_d;

  assign run         = (state_q == ST_RUN);
  assign wa          = wr_addr[IW-1:0];
  assign ra          = rd_addr[IW-1:0];
  assign wr_ok       = run & blk_select & wr_en &
                       ({1'b0, wr_addr} < (ADDR_SIZE+1)'(MEM_DEPTH));
  assign rd_ok       = run & blk_select & rd_en;
  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_SIZE+1)'(MEM_DEPTH));

  always_comb begin
    for (int i = 0; i < NB; i++)
      wr_par[i] = (^din[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ err_inject;
  end

  // Sweep / run control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IW'(MEM_DEPTH - 1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy = (state_q == ST_INIT);

  // Write port; the sweep owns the array while in INIT.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_data[cnt_q] <= '0;
      mem_par[cnt_q]  <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_data[wa][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
          mem_par[wa][i]                           <= wr_par[i];
        end
      end
    end
  end

  // Read word: the array still holds the pre-write word this cycle, so READ_FIRST
  // falls out naturally; WRITE_FIRST overlays the enabled incoming lanes.
  always_comb begin
    rd_word = '0;
    rd_par  = '0;
    rd_mm   = 1'b0;
    if (rd_in_range) begin
      rd_word = mem_data[ra];
      rd_par  = mem_par[ra];
      if (WFIRST && wr_ok && (wr_addr == rd_addr)) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) begin
            rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
            rd_par[i]                           = wr_par[i];
          end
        end
      end
    end
    if (PARITY_ENABLE != 0) begin
      for (int i = 0; i < NB; i++)
        rd_mm = rd_mm | ((^rd_word[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ rd_par[i]);
    end
  end

  // Data registers only load on a valid beat so dout holds between results;
  // error bits follow the valid bits so parity_err is 0 without dout_valid.
  always_comb begin
    vld_pipe_d[0] = rd_ok;
    err_pipe_d[0] = rd_ok & rd_mm;
    s1_data_d     = rd_ok ? rd_word : s1_data_q;
    vld_pipe_d[1] = vld_pipe_q[0];
    err_pipe_d[1] = err_pipe_q[0];
    s2_data_d     = vld_pipe_q[0] ? s1_data_q : s2_data_q;
    sticky_d      = sticky_q | (PIPE2 ? err_pipe_d[1] : err_pipe_d[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      err_pipe_q <= '0;
      s1_data_q  <= '0;
      s2_data_q  <= '0;
      sticky_q   <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      err_pipe_q <= err_pipe_d;
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
      sticky_q   <= sticky_d;
    end
  end

  assign dout              = PIPE2 ? s2_data_q     : s1_data_q;
  assign dout_valid        = PIPE2 ? vld_pipe_q[1] : vld_pipe_q[0];
  assign parity_err        = PIPE2 ? err_pipe_q[1] : err_pipe_q[0];
  assign parity_err_sticky = sticky_q;

endmodule

// File: tb/tb_ram_sdp_parity.sv
// Directed bench for ram_sdp_parity. Three instances share stimulus:
//   A: latency 2, READ_FIRST,  parity on
//   B: latency 1, WRITE_FIRST, parity on
//   C: latency 1, READ_FIRST,  parity off
module tb_ram_sdp_parity;
  localparam int W = 16, D = 16, AW = 5, NB = 2;

  logic          clk = 1'b0;
  logic          rst_n, blk_select, wr_en, err_inject, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [NB-1:0] wr_be;
  logic [W-1:0]  din;

  logic [W-1:0] dout_a, dout_b, dout_c;
  logic vld_a, vld_b, vld_c, perr_a, perr_b, perr_c;
  logic stk_a, stk_b, stk_c, busy_a, busy_b, busy_c;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  ram_sdp_parity #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(AW), .BYTE_WIDTH(8),
    .DOUT_PIPELINE("TRUE"), .RDW_MODE("READ_FIRST"), .PARITY_ENABLE(1), .INIT_CLEAR(1))
  u_a (.clk(clk), .rst_n(rst_n), .blk_select(blk_select), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .din(din), .err_inject(err_inject), .rd_en(rd_en), .rd_addr(rd_addr),
    .dout(dout_a), .dout_valid(vld_a), .parity_err(perr_a), .parity_err_sticky(stk_a),
    .init_busy(busy_a));

  ram_sdp_parity #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(AW), .BYTE_WIDTH(8),
    .DOUT_PIPELINE("FALSE"), .RDW_MODE("WRITE_FIRST"), .PARITY_ENABLE(1), .INIT_CLEAR(1))
  u_b (.clk(clk), .rst_n(rst_n), .blk_select(blk_select), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .din(din), .err_inject(err_inject), .rd_en(rd_en), .rd_addr(rd_addr),
    .dout(dout_b), .dout_valid(vld_b), .parity_err(perr_b), .parity_err_sticky(stk_b),
    .init_busy(busy_b));

  ram_sdp_parity #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(AW), .BYTE_WIDTH(8),
    .DOUT_PIPELINE("FALSE"), .RDW_MODE("READ_FIRST"), .PARITY_ENABLE(0), .INIT_CLEAR(1))
  u_c (.clk(clk), .rst_n(rst_n), .blk_select(blk_select), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .din(din), .err_inject(err_inject), .rd_en(rd_en), .rd_addr(rd_addr),
    .dout(dout_c), .dout_valid(vld_c), .parity_err(perr_c), .parity_err_sticky(stk_c),
    .init_busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; one write cycle.
  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NB-1:0] be,
                    input logic inj);
    wr_en = 1'b1; wr_addr = a; din = d; wr_be = be; err_inject = inj;
    @(negedge clk);
    wr_en = 1'b0; err_inject = 1'b0;
  endtask

  // One read (optionally alongside a write already set up by the caller).
  // B and C answer one cycle later, A two cycles later; then all go quiet.
  task automatic rd_chk(input string tag, input logic [AW-1:0] a,
                        input logic [W-1:0] ea, input logic [W-1:0] eb, input logic [W-1:0] ec,
                        input logic pa, input logic pb, input logic pc);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0; err_inject = 1'b0;
    chk({tag, "_b_vld"}, vld_b, 1);  chk({tag, "_b_dout"}, dout_b, eb);
    chk({tag, "_b_perr"}, perr_b, pb);
    chk({tag, "_c_vld"}, vld_c, 1);  chk({tag, "_c_dout"}, dout_c, ec);
    chk({tag, "_c_perr"}, perr_c, pc);
    chk({tag, "_a_vld_early"}, vld_a, 0);
    @(negedge clk);
    chk({tag, "_a_vld"}, vld_a, 1);  chk({tag, "_a_dout"}, dout_a, ea);
    chk({tag, "_a_perr"}, perr_a, pa);
    chk({tag, "_b_vld_off"}, vld_b, 0); chk({tag, "_b_hold"}, dout_b, eb);
    chk({tag, "_b_perr_off"}, perr_b, 0);
    @(negedge clk);
    chk({tag, "_a_vld_off"}, vld_a, 0); chk({tag, "_a_perr_off"}, perr_a, 0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    rst_n = 1'b0; blk_select = 1'b1; wr_en = 1'b0; err_inject = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; din = '0;
    @(negedge clk); @(negedge clk);

    // Reset state
    chk("rst_dout", dout_a, 0);   chk("rst_vld", vld_a, 0);
    chk("rst_perr", perr_a, 0);   chk("rst_sticky", stk_a, 0);
    chk("rst_busy_a", busy_a, 1); chk("rst_busy_b", busy_b, 1);
    chk("rst_busy_c", busy_c, 1);

    // Start a sweep, interrupt it at counter 9
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    chk("mid_busy", busy_a, 1);
    rst_n = 1'b0;
    #1 chk("mid_rst_busy", busy_a, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep: busy for D cycles, reads issued meanwhile are dropped
    rd_en = 1'b1; rd_addr = 5'd1;
    cyc = 0; seen = 0;
    while (busy_a && cyc < 100) begin
      cyc++;
      @(negedge clk);
      if (vld_a | vld_b | vld_c) seen = 1;
    end
    rd_en = 1'b0;
    chk("init_len", cyc, D);
    chk("init_no_vld", seen, 0);
    chk("init_done_b", busy_b, 0);
    chk("init_done_c", busy_c, 0);
    @(negedge clk);
    chk("init_no_vld_a", vld_a, 0);

    // Back-to-back reads of the whole cleared array
    for (int i = 0; i <= D; i++) begin
      rd_en = (i < D); rd_addr = AW'(i);
      @(negedge clk);
      chk($sformatf("b2b%0d_b_vld", i), vld_b, (i < D));
      chk($sformatf("b2b%0d_a_vld", i), vld_a, (i >= 1));
      if (i < D) begin
        chk($sformatf("b2b%0d_b_dout", i), dout_b, 0);
        chk($sformatf("b2b%0d_b_perr", i), perr_b, 0);
      end
      if (i >= 1) chk($sformatf("b2b%0d_a_dout", i), dout_a, 0);
    end
    rd_en = 1'b0;
    @(negedge clk);

    // Byte-enable merge
    wr(5, 16'hA5C3, 2'b11, 0);
    wr(5, 16'hFF00, 2'b01, 0);
    rd_chk("be5", 5, 16'hA500, 16'hA500, 16'hA500, 0, 0, 0);

    // Read-during-write, full word then partial word
    wr(7, 16'h1234, 2'b11, 0);
    wr_en = 1'b1; wr_addr = 7; din = 16'hBEEF; wr_be = 2'b11;
    rd_chk("rdw7", 7, 16'h1234, 16'hBEEF, 16'h1234, 0, 0, 0);
    rd_chk("rdw7_after", 7, 16'hBEEF, 16'hBEEF, 16'hBEEF, 0, 0, 0);
    wr(9, 16'h1234, 2'b11, 0);
    wr_en = 1'b1; wr_addr = 9; din = 16'hABCD; wr_be = 2'b01;
    rd_chk("rdw9", 9, 16'h1234, 16'h12CD, 16'h1234, 0, 0, 0);
    rd_chk("rdw9_after", 9, 16'h12CD, 16'h12CD, 16'h12CD, 0, 0, 0);

    // Parity error injection
    chk("stk_pre_a", stk_a, 0);
    wr(3, 16'h00FF, 2'b01, 1);
    rd_chk("perr3", 3, 16'h00FF, 16'h00FF, 16'h00FF, 1, 1, 0);
    chk("stk_a", stk_a, 1); chk("stk_b", stk_b, 1); chk("stk_c", stk_c, 0);
    rd_chk("clean5", 5, 16'hA500, 16'hA500, 16'hA500, 0, 0, 0);
    chk("stk_a_hold", stk_a, 1);

    // Gated, disabled and out-of-range accesses
    blk_select = 1'b0;
    rd_en = 1'b1; rd_addr = 2;
    wr(2, 16'hDEAD, 2'b11, 0);
    rd_en = 1'b0; blk_select = 1'b1;
    chk("blk_rd_b", vld_b, 0);
    @(negedge clk);
    chk("blk_rd_a", vld_a, 0);
    wr(20, 16'h1111, 2'b11, 0);
    wr(5, 16'hFFFF, 2'b00, 0);
    rd_chk("blk2", 2, 0, 0, 0, 0, 0, 0);
    rd_chk("oor_alias4", 4, 0, 0, 0, 0, 0, 0);
    rd_chk("oor20", 20, 0, 0, 0, 0, 0, 0);
    rd_chk("be0_5", 5, 16'hA500, 16'hA500, 16'hA500, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_sdp_parity.md
Name: ram_sdp_parity

Overview:
- Parametrised simple-dual-port RAM with one write port and one read port, both on the same clock.
- Adds per-byte write enables, stored per-byte parity with read-side checking, and a selectable read-during-write mode.
- Adds a post-reset memory-clear sweep and a selectable 1- or 2-cycle read latency with a dout_valid strobe.
- Successor to the single-port RAM; it is the storage primitive for buffers and FIFOs in the datapath.

Parameters:
- MEM_WIDTH, 16, data word width; must be a multiple of BYTE_WIDTH.
- MEM_DEPTH, 1024, number of words; must be ≤ 2**ADDR_SIZE.
- ADDR_SIZE, 10, address width.
- BYTE_WIDTH, 8, bits per byte lane. NB = MEM_WIDTH/BYTE_WIDTH.
- DOUT_PIPELINE, "TRUE", "TRUE" gives read latency 2; "FALSE" gives read latency 1.
- RDW_MODE, "READ_FIRST", same-address read and write in one cycle returns old data ("READ_FIRST") or new merged data ("WRITE_FIRST").
- PARITY_ENABLE, 1, 1 stores and checks parity; 0 forces parity_err and parity_err_sticky to 0.
- INIT_CLEAR, 1, 1 runs the zeroing sweep after reset; 0 skips it (memory contents undefined).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- blk_select  in  1  gates both ports; when low, wr_en and rd_en are ignored
- wr_en  in  1  write request
- wr_addr  in  ADDR_SIZE  write address
- wr_be  in  NB  byte-lane write enables; bit i maps to din[i*BYTE_WIDTH +: BYTE_WIDTH]
- din  in  MEM_WIDTH  write data
- err_inject  in  1  when high with an accepted write, stores inverted parity for the enabled lanes
- rd_en  in  1  read request
- rd_addr  in  ADDR_SIZE  read address
- dout  out  MEM_WIDTH  read data
- dout_valid  out  1  one-cycle strobe qualifying dout
- parity_err  out  1  parity mismatch on the current dout; asserted only with dout_valid
- parity_err_sticky  out  1  set on any parity_err; cleared only by reset
- init_busy  out  1  clear sweep in progress; requests are dropped while high

Behaviour:
- Reset (rst_n=0, async), outputs:
  - dout=0, dout_valid=0, parity_err=0, parity_err_sticky=0.
  - init_busy=1 if INIT_CLEAR=1, else 0.
  - Pipeline valid bits and sweep counter cleared.
  - Memory array is not reset asynchronously.
- Storage: each word holds MEM_WIDTH data bits plus NB parity bits. Parity bit i = ^(data lane i), XORed with err_inject at write time.
- State machine, two states, INIT and RUN:
  - Reset enters INIT when INIT_CLEAR=1, otherwise RUN.
  - INIT: counter steps 0..MEM_DEPTH-1, writing data 0 and parity 0 at one address per cycle, for exactly MEM_DEPTH cycles.
  - At the end of INIT, go to RUN; init_busy falls on the edge after address MEM_DEPTH-1 is written.
  - Reset asserted mid-sweep restarts the sweep from address 0.
  - In INIT, wr_en and rd_en are dropped, not queued; dout_valid stays 0.
- Write (RUN): accepted when blk_select & wr_en & wr_addr<MEM_DEPTH.
  - Only lanes with wr_be[i]=1 update, both data and parity.
  - wr_be=0 performs no write.
  - wr_addr ≥ MEM_DEPTH: write ignored.
- Read (RUN): accepted when blk_select & rd_en.
  - Stage 1 registers the raw word and the mismatch flag.
  - Mismatch = OR over lanes of (^lane ^ stored parity).
  - DOUT_PIPELINE="FALSE": dout and dout_valid update at edge N+1 for a request sampled at edge N (latency 1).
  - DOUT_PIPELINE="TRUE": one extra register stage (latency 2).
  - Back-to-back reads are fully pipelined, one result per cycle.
  - rd_addr ≥ MEM_DEPTH: returns dout=0, parity_err=0, dout_valid still pulses.
- dout holds its last value when dout_valid=0; parity_err is 0 whenever dout_valid=0.
- Read-during-write to the same address, same cycle:
  - READ_FIRST returns the pre-write word.
  - WRITE_FIRST returns the merged word: new lanes where wr_be=1, old lanes elsewhere, with the merged parity check result.
  - Different addresses do not interact.
- parity_err_sticky: set on the same edge parity_err asserts.

Test Plan:
- Reset, then INIT_CLEAR=1, MEM_DEPTH=16 → init_busy high 16 cycles; read of all addresses returns 0x0000, dout_valid each cycle, parity_err=0.
- Write 0xA5C3 to addr 5 with wr_be=2'b11, then write 0xFF00 to addr 5 with wr_be=2'b01 → read addr 5 returns 0xA500; DOUT_PIPELINE="TRUE" gives dout_valid 2 cycles after rd_en, "FALSE" gives 1 cycle after.
- Addr 7 holds 0x1234; same-cycle write 0xBEEF (wr_be=2'b11) and read of addr 7 → READ_FIRST returns 0x1234, WRITE_FIRST returns 0xBEEF; next read returns 0xBEEF in both modes.
- Write 0x00FF to addr 3 with err_inject=1 and wr_be=2'b01 → read addr 3 gives dout=0x00FF, parity_err=1 for one cycle, parity_err_sticky stays 1; with PARITY_ENABLE=0 both flags stay 0.
- Reset pulse mid-sweep at counter=9 → sweep restarts at 0 and init_busy lasts MEM_DEPTH cycles after release; rd_en issued during init produces no dout_valid.
- blk_select=0 with wr_en=1 to addr 2, and a write to addr ≥ MEM_DEPTH → addr 2 contents unchanged; out-of-range read gives dout=0 with dout_valid=1.
